// File: rtl/inst_rom_arbiter.sv
// Two-port arbiter in front of the single-ported instruction ROM (fetch / load).
// Define INST_ROM_ARB_RR_EN for round-robin arbitration; fixed priority otherwise.
module inst_rom_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ROM_AW = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              kill0,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  logic              w_e0;
  logic              w_e1;
  logic              w_g0;
  logic              w_g1;
  logic              w_bad;
  logic [ADDR_W-1:0] w_addr;

  logic              r_ack0;
  logic              r_ack1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              r_err0;
  logic              r_err1;

  assign w_e0 = req0 & ~kill0;
  assign w_e1 = req1;

`ifdef INST_ROM_ARB_RR_EN
  logic r_ptr;

  always_comb begin
    w_g0 = w_e0 & (~w_e1 | ~r_ptr);
    w_g1 = w_e1 & (~w_e0 | r_ptr);
  end

  // Pointer names the port that lost (or did not win) the last grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (w_g0) begin
      r_ptr <= 1'b1;
    end else if (w_g1) begin
      r_ptr <= 1'b0;
    end
  end
`else
  always_comb begin
    w_g1 = w_e1;
    w_g0 = w_e0 & ~w_e1;
  end
`endif

  always_comb begin
    w_addr   = w_g1 ? addr1 : addr0;
    w_bad    = (|w_addr[1:0]) | (|w_addr[ADDR_W-1:ROM_AW+2]);
    rom_en   = rst_n & (w_g0 | w_g1) & ~w_bad;
    rom_addr = rom_en ? w_addr : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
    end else begin
      r_ack0 <= w_g0;
      r_ack1 <= w_g1;
      if (w_g0) begin
        r_rdata0 <= w_bad ? '0 : rom_data;
        r_err0   <= w_bad;
      end
      if (w_g1) begin
        r_rdata1 <= w_bad ? '0 : rom_data;
        r_err1   <= w_bad;
      end
    end
  end

  // A flush in the ack cycle drops the pending fetch result.
  assign ack0   = r_ack0 & ~kill0;
  assign ack1   = r_ack1;
  assign rdata0 = r_rdata0;
  assign rdata1 = r_rdata1;
  assign err0   = r_err0;
  assign err1   = r_err1;

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Bench for inst_rom_arbiter: vector table with an ack scoreboard,
// plus reset-in-flight and conflict sequences.
module tb_inst_rom_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0;
  logic        req1;
  logic [31:0] addr0;
  logic [31:0] addr1;
  logic        kill0;
  logic        ack0;
  logic        ack1;
  logic [31:0] rdata0;
  logic [31:0] rdata1;
  logic        err0;
  logic        err1;
  logic        rom_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit          r0;
    logic [31:0] a0;
    bit          r1;
    logic [31:0] a1;
    bit          k;
    bit          en;
    logic [31:0] ra;
    int          gp;
    logic [31:0] gd;
    bit          ge;
  } vec_t;

  typedef struct {
    int          gp;
    logic [31:0] gd;
    bit          ge;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  inst_rom_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .kill0(kill0),
    .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data)
  );

  function automatic logic [31:0] rw(input int i);
    if (i == 4) return 32'h2402_0005;
    return 32'hC0DE_0000 + i;
  endfunction

  assign rom_data = rw(int'(rom_addr[18:2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add(input bit r0, input logic [31:0] a0, input bit r1,
                     input logic [31:0] a1, input bit k, input bit en,
                     input logic [31:0] ra, input int gp,
                     input logic [31:0] gd, input bit ge);
    vec_t v;
    v = '{r0, a0, r1, a1, k, en, ra, gp, gd, ge};
    tbl.push_back(v);
  endtask

  task automatic apply(input vec_t v, input string nm);
    exp_t e;
    bit   x0;
    bit   x1;
    @(posedge clk);
    #1;
    req0 = v.r0; addr0 = v.a0;
    req1 = v.r1; addr1 = v.a1;
    kill0 = v.k;
    #2;
    if (sb.size() == 0) e = '{-1, 32'h0, 1'b0};
    else e = sb.pop_front();
    x0 = (e.gp == 0) && !v.k;
    x1 = (e.gp == 1);
    chk({nm, " ack0"}, {31'b0, ack0}, {31'b0, x0});
    chk({nm, " ack1"}, {31'b0, ack1}, {31'b0, x1});
    if (x0) begin
      chk({nm, " rdata0"}, rdata0, e.gd);
      chk({nm, " err0"}, {31'b0, err0}, {31'b0, e.ge});
    end
    if (x1) begin
      chk({nm, " rdata1"}, rdata1, e.gd);
      chk({nm, " err1"}, {31'b0, err1}, {31'b0, e.ge});
    end
    chk({nm, " rom_en"}, {31'b0, rom_en}, {31'b0, v.en});
    chk({nm, " rom_addr"}, rom_addr, v.ra);
    sb.push_back('{v.gp, v.gd, v.ge});
  endtask

  task automatic idle(input string nm);
    vec_t v;
    v = '{0, 32'h0, 0, 32'h0, 0, 0, 32'h0, -1, 32'h0, 0};
    apply(v, nm);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " ack0"}, {31'b0, ack0}, 32'h0);
    chk({nm, " ack1"}, {31'b0, ack1}, 32'h0);
    chk({nm, " rdata0"}, rdata0, 32'h0);
    chk({nm, " rdata1"}, rdata1, 32'h0);
    chk({nm, " err0"}, {31'b0, err0}, 32'h0);
    chk({nm, " err1"}, {31'b0, err1}, 32'h0);
    chk({nm, " rom_en"}, {31'b0, rom_en}, 32'h0);
    chk({nm, " rom_addr"}, rom_addr, 32'h0);
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0;
    req0 = 1'b1; addr0 = 32'h10;
    req1 = 1'b0; addr1 = 32'h0;
    kill0 = 1'b0;
    #3;
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req0 = 1'b0;

    // single fetch, then stream of three
    add(1, 32'h10, 0, 32'h0, 0, 1, 32'h10, 0, 32'h2402_0005, 0);
    add(1, 32'h0,  0, 32'h0, 0, 1, 32'h0,  0, rw(0), 0);
    add(1, 32'h4,  0, 32'h0, 0, 1, 32'h4,  0, rw(1), 0);
    add(1, 32'h8,  0, 32'h0, 0, 1, 32'h8,  0, rw(2), 0);
    add(0, 32'h0,  0, 32'h0, 0, 0, 32'h0, -1, 32'h0, 0);
    // conflict: load wins, fetch follows
    add(1, 32'h20, 1, 32'h40, 0, 1, 32'h40, 1, rw(16), 0);
    add(1, 32'h20, 0, 32'h0,  0, 1, 32'h20, 0, rw(8), 0);
    add(0, 32'h0,  0, 32'h0,  0, 0, 32'h0, -1, 32'h0, 0);
    // bad and boundary addresses
    add(0, 32'h0, 1, 32'h6,     0, 0, 32'h0,     1, 32'h0, 1);
    add(0, 32'h0, 1, 32'h80000, 0, 0, 32'h0,     1, 32'h0, 1);
    add(0, 32'h0, 1, 32'h7FFFC, 0, 1, 32'h7FFFC, 1, rw(32'h1FFFF), 0);
    add(0, 32'h0, 0, 32'h0,     0, 0, 32'h0,    -1, 32'h0, 0);
    // kill pending fetch, kill blocks grant, kill with load
    add(1, 32'h20, 0, 32'h0,  0, 1, 32'h20, 0, rw(8), 0);
    add(0, 32'h0,  0, 32'h0,  1, 0, 32'h0, -1, 32'h0, 0);
    add(1, 32'h24, 0, 32'h0,  1, 0, 32'h0, -1, 32'h0, 0);
    add(1, 32'h24, 1, 32'h44, 1, 1, 32'h44, 1, rw(17), 0);
    add(0, 32'h0,  0, 32'h0,  0, 0, 32'h0, -1, 32'h0, 0);

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // reset after capture: pending ack and data are cleared
    v = '{0, 32'h0, 1, 32'h8, 0, 1, 32'h8, 1, rw(2), 0};
    apply(v, "pre_rst");
    @(posedge clk);
    #1;
    req1 = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero("rst_after_cap");
    #2;
    rst_n = 1'b1;
    sb.delete();
    idle("post_rst_a");

    // reset inside the grant cycle, before the capture edge
    @(posedge clk);
    #1;
    req1 = 1'b1; addr1 = 32'h8;
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("rst_in_grant");
    #1;
    req1 = 1'b0;
    #2;
    rst_n = 1'b1;
    sb.delete();
    for (int i = 0; i < 3; i++) idle($sformatf("post_rst_b%0d", i));

    // continuous conflict from the reset pointer
    for (int i = 0; i < 4; i++) begin
`ifdef INST_ROM_ARB_RR_EN
      if (i % 2 == 0) v = '{1, 32'h0, 1, 32'h4, 0, 1, 32'h0, 0, rw(0), 0};
      else v = '{1, 32'h0, 1, 32'h4, 0, 1, 32'h4, 1, rw(1), 0};
`else
      v = '{1, 32'h0, 1, 32'h4, 0, 1, 32'h4, 1, rw(1), 0};
`endif
      apply(v, $sformatf("conf%0d", i));
    end
    idle("conf_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
